// File: rtl/jtoutrun_obj_draw.sv
// Sprite draw engine: fetches 4bpp words from object ROM and writes zoomed,
// flipped pixels into the object line buffer, one command at a time.
module jtoutrun_obj_draw #(
    parameter logic [8:0] XOFFSET = 9'd0,
    parameter logic [9:0] MAXPX   = 10'd512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dr_start,
    output logic        dr_busy,
    input  logic [8:0]  dr_xpos,
    input  logic [15:0] dr_offset,
    input  logic [2:0]  dr_bank,
    input  logic [1:0]  dr_prio,
    input  logic        dr_shadow,
    input  logic [6:0]  dr_pal,
    input  logic [9:0]  dr_hzoom,
    input  logic        dr_hflip,
    input  logic        dr_backwd,
    output logic [17:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [31:0] rom_data,
    output logic [8:0]  buf_addr,
    output logic [13:0] buf_data,
    output logic        buf_we
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_DRAW = 2'd2} state_t;

    // pixel 0 lives in the top nibble
    function automatic logic [3:0] nibble_sel(input logic [31:0] word, input logic [2:0] idx);
        logic [4:0] lsb;
        lsb = 5'd28 - {idx, 2'b00};
        return word[lsb +: 4];
    endfunction

    state_t       state_r, state_s;
    logic [8:0]   x_r, x_s;
    logic [2:0]   sidx_r, sidx_s;
    logic [8:0]   acc_r, acc_s;
    logic [9:0]   cnt_r, cnt_s;
    logic [14:0]  offset_r, offset_s;
    logic         busy_r, busy_s;
    logic [2:0]   bank_r, bank_s;
    logic [1:0]   prio_r;
    logic         shadow_r;
    logic [6:0]   pal_r;
    logic [9:0]   hzoom_r;
    logic         hflip_r, backwd_r;
    logic [31:0]  word_r;
    logic         rom_cs_r, rom_cs_s, cs_prev_r;
    logic [17:0]  rom_addr_r;
    logic         buf_we_r;
    logic [8:0]   buf_addr_r;
    logic [13:0]  buf_data_r;
    logic         load_s, capture_s, we_s;
    logic [3:0]   pix_s;
    logic [10:0]  sum_s;
    logic [1:0]   adv_s;
    logic [3:0]   step_s;
    logic         unused_s;

    assign unused_s = dr_offset[15];
    assign dr_busy  = busy_r;
    assign rom_cs   = rom_cs_r;
    assign rom_addr = rom_addr_r;
    assign buf_we   = buf_we_r;
    assign buf_addr = buf_addr_r;
    assign buf_data = buf_data_r;

    // Next-state logic and datapath updates for the draw FSM
    always_comb begin
        state_s   = state_r;
        x_s       = x_r;
        sidx_s    = sidx_r;
        acc_s     = acc_r;
        cnt_s     = cnt_r;
        offset_s  = offset_r;
        busy_s    = busy_r;
        load_s    = 1'b0;
        capture_s = 1'b0;
        we_s      = 1'b0;
        pix_s     = nibble_sel(word_r, sidx_r);
        sum_s     = {2'b00, acc_r} + {1'b0, hzoom_r};
        adv_s     = sum_s[10:9];
        // bit 3 of the step flags a word crossing in either direction
        step_s    = hflip_r ? ({1'b0, sidx_r} - {2'b00, adv_s})
                            : ({1'b0, sidx_r} + {2'b00, adv_s});
        case (state_r)
            ST_IDLE: begin
                if (dr_start) begin
                    load_s   = 1'b1;
                    x_s      = dr_xpos + XOFFSET;
                    sidx_s   = dr_hflip ? 3'd7 : 3'd0;
                    acc_s    = 9'd0;
                    cnt_s    = 10'd0;
                    offset_s = dr_offset[14:0];
                    busy_s   = 1'b1;
                    state_s  = ST_FETCH;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (rom_cs_r && cs_prev_r && rom_ok) begin
                    capture_s = 1'b1;
                    state_s   = ST_DRAW;
                end else begin
                    state_s   = ST_FETCH;
                end
            end
            ST_DRAW: begin
                if ((hzoom_r == 10'd0) || (pix_s == 4'hF)) begin
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    we_s   = (pix_s != 4'h0);
                    x_s    = backwd_r ? (x_r - 9'd1) : (x_r + 9'd1);
                    cnt_s  = cnt_r + 10'd1;
                    acc_s  = sum_s[8:0];
                    sidx_s = step_s[2:0];
                    if (cnt_s == MAXPX) begin
                        busy_s  = 1'b0;
                        state_s = ST_IDLE;
                    end else if (step_s[3]) begin
                        offset_s = hflip_r ? (offset_r - 15'd1) : (offset_r + 15'd1);
                        state_s  = ST_FETCH;
                    end else begin
                        state_s  = ST_DRAW;
                    end
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
        // a pending pixel write delays the ROM request by one cycle
        rom_cs_s = (state_s == ST_FETCH) && !we_s;
        bank_s   = load_s ? dr_bank : bank_r;
    end

    // State, command latches and traversal registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            x_r      <= 9'd0;
            sidx_r   <= 3'd0;
            acc_r    <= 9'd0;
            cnt_r    <= 10'd0;
            offset_r <= 15'd0;
            busy_r   <= 1'b0;
            bank_r   <= 3'd0;
            prio_r   <= 2'd0;
            shadow_r <= 1'b0;
            pal_r    <= 7'd0;
            hzoom_r  <= 10'd0;
            hflip_r  <= 1'b0;
            backwd_r <= 1'b0;
            word_r   <= 32'd0;
        end else begin
            state_r  <= state_s;
            x_r      <= x_s;
            sidx_r   <= sidx_s;
            acc_r    <= acc_s;
            cnt_r    <= cnt_s;
            offset_r <= offset_s;
            busy_r   <= busy_s;
            bank_r   <= bank_s;
            if (load_s) begin
                prio_r   <= dr_prio;
                shadow_r <= dr_shadow;
                pal_r    <= dr_pal;
                hzoom_r  <= dr_hzoom;
                hflip_r  <= dr_hflip;
                backwd_r <= dr_backwd;
            end
            if (capture_s) begin
                word_r <= rom_data;
            end
        end
    end

    // Registered ROM request and line-buffer write port
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_cs_r   <= 1'b0;
            cs_prev_r  <= 1'b0;
            rom_addr_r <= 18'd0;
            buf_we_r   <= 1'b0;
            buf_addr_r <= 9'd0;
            buf_data_r <= 14'd0;
        end else begin
            rom_cs_r  <= rom_cs_s;
            cs_prev_r <= rom_cs_r;
            if (rom_cs_s) begin
                rom_addr_r <= {bank_s, offset_s};
            end
            buf_we_r <= we_s;
            if (we_s) begin
                buf_addr_r <= x_r;
                buf_data_r <= {shadow_r, prio_r, pal_r, pix_s};
            end
        end
    end

endmodule

// File: tb/tb_jtoutrun_obj_draw.sv
// Randomised bench for jtoutrun_obj_draw: a ROM responder feeds the engine and
// every write/fetch is compared against a source-position reference model.
module tb_jtoutrun_obj_draw;

    localparam int MAXPX = 512;
    localparam int XOFF  = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        dr_start;
    logic        dr_busy;
    logic [8:0]  dr_xpos;
    logic [15:0] dr_offset;
    logic [2:0]  dr_bank;
    logic [1:0]  dr_prio;
    logic        dr_shadow;
    logic [6:0]  dr_pal;
    logic [9:0]  dr_hzoom;
    logic        dr_hflip;
    logic        dr_backwd;
    logic [17:0] rom_addr;
    logic        rom_cs;
    logic        rom_ok;
    logic [31:0] rom_data;
    logic [8:0]  buf_addr;
    logic [13:0] buf_data;
    logic        buf_we;

    jtoutrun_obj_draw dut (
        .clk(clk), .rst(rst), .dr_start(dr_start), .dr_busy(dr_busy),
        .dr_xpos(dr_xpos), .dr_offset(dr_offset), .dr_bank(dr_bank),
        .dr_prio(dr_prio), .dr_shadow(dr_shadow), .dr_pal(dr_pal),
        .dr_hzoom(dr_hzoom), .dr_hflip(dr_hflip), .dr_backwd(dr_backwd),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] mem [int];
    logic [31:0] fill_word = 32'd0;

    function automatic logic [31:0] rom_word(input int addr);
        if (mem.exists(addr)) return mem[addr];
        return fill_word;
    endfunction

    int got_wr[$];
    int got_fetch[$];
    int exp_wr[$];
    int exp_fetch[$];

    int lat_min = 0;
    int lat_max = 3;
    bit spurious = 1'b0;
    int wait_left = 0;
    bit prev_cs_b = 1'b0;
    bit delivered_b = 1'b0;
    int cs_drop = 0;
    int overlap = 0;

    // ROM responder and write monitor, both acting on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            rom_ok      = 1'b0;
            delivered_b = 1'b0;
        end else begin
            if (prev_cs_b && !rom_cs && !delivered_b) cs_drop++;
            if (!rom_cs) begin
                rom_ok   = 1'b0;
                rom_data = 32'd0;
            end else if (!prev_cs_b) begin
                delivered_b = 1'b0;
                wait_left   = $urandom_range(lat_max, lat_min);
                rom_ok      = spurious;
                rom_data    = 32'hFFFF_FFFF;
            end else if (delivered_b) begin
                rom_ok = 1'b0;
            end else if (wait_left > 0) begin
                wait_left--;
                rom_ok = 1'b0;
            end else begin
                rom_ok      = 1'b1;
                rom_data    = rom_word(int'(rom_addr));
                delivered_b = 1'b1;
                got_fetch.push_back(int'(rom_addr));
            end
            if (rom_cs && buf_we) overlap++;
            if (buf_we) got_wr.push_back(int'({buf_addr, buf_data}));
        end
        prev_cs_b = rom_cs;
    end

    // Reference: output pixel n samples source pixel start +/- floor(n*hzoom/512)
    task automatic model(input logic [8:0] xpos, input logic [15:0] off, input logic [2:0] bank,
                         input logic [1:0] prio, input logic sh, input logic [6:0] pal,
                         input logic [9:0] hz, input logic hf, input logic bw);
        int base, cur_w, src, w, nib, x, adv, waddr;
        logic [31:0] word;
        logic [3:0]  p;
        exp_wr.delete();
        exp_fetch.delete();
        base  = (int'(off[14:0]) + 32768 * 4) * 8 + (hf ? 7 : 0);
        cur_w = -1;
        for (int n = 0; n < MAXPX; n++) begin
            adv   = (n * int'(hz)) / 512;
            src   = hf ? base - adv : base + adv;
            w     = (src / 8) % 32768;
            nib   = src % 8;
            waddr = int'(bank) * 32768 + w;
            if (w != cur_w) begin
                exp_fetch.push_back(waddr);
                cur_w = w;
            end
            if (hz == 10'd0) break;
            word = rom_word(waddr);
            p    = word[(28 - 4 * nib) +: 4];
            if (p == 4'hF) break;
            x = (int'(xpos) + XOFF + (bw ? 1024 - n : n)) % 512;
            if (p != 4'h0) exp_wr.push_back(x * 16384 + int'({sh, prio, pal, p}));
        end
    endtask

    task automatic drive(input logic [8:0] xpos, input logic [15:0] off, input logic [2:0] bank,
                         input logic [1:0] prio, input logic sh, input logic [6:0] pal,
                         input logic [9:0] hz, input logic hf, input logic bw);
        dr_xpos = xpos; dr_offset = off; dr_bank = bank; dr_prio = prio;
        dr_shadow = sh; dr_pal = pal; dr_hzoom = hz; dr_hflip = hf; dr_backwd = bw;
    endtask

    task automatic run_cmd(input string tag, input logic [8:0] xpos, input logic [15:0] off,
                           input logic [2:0] bank, input logic [1:0] prio, input logic sh,
                           input logic [6:0] pal, input logic [9:0] hz, input logic hf,
                           input logic bw, input bit poke);
        int cyc;
        model(xpos, off, bank, prio, sh, pal, hz, hf, bw);
        got_wr.delete();
        got_fetch.delete();
        drive(xpos, off, bank, prio, sh, pal, hz, hf, bw);
        dr_start = 1'b1;
        @(negedge clk); #1;
        dr_start = 1'b0;
        check({tag, ".busy_rise"}, dr_busy, 1);
        cyc = 0;
        while (dr_busy && cyc < 6000) begin
            if (poke && cyc == 3) begin
                dr_start = 1'b1; dr_xpos = ~xpos; dr_offset = ~off; dr_hzoom = 10'd0;
            end else begin
                dr_start = 1'b0;
            end
            @(negedge clk); #1;
            cyc++;
        end
        dr_start = 1'b0;
        check({tag, ".timeout"}, dr_busy, 0);
        check({tag, ".nwr"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check($sformatf("%s.wr%0d", tag, i), got_wr[i], exp_wr[i]);
        check({tag, ".nfetch"}, got_fetch.size(), exp_fetch.size());
        for (int i = 0; i < exp_fetch.size() && i < got_fetch.size(); i++)
            check($sformatf("%s.fetch%0d", tag, i), got_fetch[i], exp_fetch[i]);
        if (poke) begin
            repeat (3) @(negedge clk);
            #1;
            check({tag, ".ignored_start"}, dr_busy, 0);
        end
    endtask

    function automatic logic [31:0] rand_word(input bit allow_f);
        logic [31:0] wv;
        for (int k = 0; k < 8; k++) begin
            if (allow_f && $urandom_range(29, 0) == 0) wv[k*4 +: 4] = 4'hF;
            else wv[k*4 +: 4] = 4'($urandom_range(14, 0));
        end
        return wv;
    endfunction

    initial begin
        int cyc;
        logic [15:0] off;
        logic [2:0]  bank;
        logic [9:0]  hz;
        rst = 1'b1; dr_start = 1'b0; rom_ok = 1'b0; rom_data = 32'd0;
        drive(9'd0, 16'd0, 3'd0, 2'd0, 1'b0, 7'd0, 10'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst.busy", dr_busy, 0);
        check("rst.rom_cs", rom_cs, 0);
        check("rst.buf_we", buf_we, 0);
        check("rst.rom_addr", rom_addr, 0);
        check("rst.buf_addr", buf_addr, 0);
        check("rst.buf_data", buf_data, 0);
        rst = 1'b0;
        @(negedge clk); #1;

        // 1:1 draw across two words, ended by F
        mem[2 * 32768 + 'h100] = 32'h1234_5678;
        mem[2 * 32768 + 'h101] = 32'h9ABC_DEF0;
        run_cmd("plain", 9'd10, 16'h0100, 3'd2, 2'd1, 1'b0, 7'h55, 10'h200, 1'b0, 1'b0, 1'b0);
        check("plain.fetch0_abs", got_fetch.size() > 0 ? got_fetch[0] : -1, 32'h10100);
        check("plain.fetch1_abs", got_fetch.size() > 1 ? got_fetch[1] : -1, 32'h10101);

        // hflip: right-to-left, next word is offset-1
        mem[2 * 32768 + 'hFF] = 32'h0000_000F;
        run_cmd("hflip", 9'd10, 16'h0100, 3'd2, 2'd3, 1'b1, 7'h12, 10'h200, 1'b1, 1'b0, 1'b0);
        check("hflip.fetch1_abs", got_fetch.size() > 1 ? got_fetch[1] : -1, 32'h100FF);
        check("hflip.first_wr", got_wr.size() > 0 ? got_wr[0] : -1, (10 * 16384) + {1'b1, 2'd3, 7'h12, 4'h8});

        // 2x zoom, backward, including the x wrap below 0
        mem.delete();
        fill_word = 32'h1FFF_FFFF;
        run_cmd("zoom2_bw", 9'd2, 16'h0040, 3'd1, 2'd0, 1'b0, 7'h01, 10'h100, 1'b0, 1'b1, 1'b0);
        run_cmd("zoom2_wrap", 9'd0, 16'h0040, 3'd1, 2'd0, 1'b0, 7'h01, 10'h100, 1'b0, 1'b1, 1'b0);
        check("zoom2_wrap.wr1", got_wr.size() > 1 ? got_wr[1] : -1, (511 * 16384) + {1'b0, 2'd0, 7'h01, 4'h1});

        // no end marker: forced termination after MAXPX pixels
        fill_word = 32'h1020_3040;
        run_cmd("maxpx", 9'd100, 16'h7FF0, 3'd5, 2'd2, 1'b0, 7'h7F, 10'h200, 1'b0, 1'b0, 1'b0);
        check("maxpx.nwr_abs", got_wr.size(), 256);
        check("maxpx.nfetch_abs", got_fetch.size(), 64);

        // slow ROM with a spurious early rom_ok, and a start pulse while busy
        lat_min = 5; lat_max = 5; spurious = 1'b1;
        fill_word = 32'h2121_2121;
        run_cmd("slowrom", 9'd300, 16'h1234, 3'd3, 2'd1, 1'b1, 7'h2A, 10'h180, 1'b0, 1'b0, 1'b1);
        lat_min = 0; lat_max = 3; spurious = 1'b0;

        // zero zoom: one fetch and no writes
        run_cmd("zoom0", 9'd50, 16'h0010, 3'd0, 2'd0, 1'b0, 7'h00, 10'h000, 1'b0, 1'b0, 1'b0);

        // reset in the middle of drawing
        fill_word = 32'h1111_1111;
        drive(9'd20, 16'h0200, 3'd4, 2'd1, 1'b0, 7'h03, 10'h200, 1'b0, 1'b0);
        dr_start = 1'b1;
        @(negedge clk); #1;
        dr_start = 1'b0;
        cyc = 0;
        while (!buf_we && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("rstmid.saw_write", buf_we, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid.buf_we", buf_we, 0);
        check("rstmid.busy", dr_busy, 0);
        check("rstmid.rom_cs", rom_cs, 0);
        #1;
        rst = 1'b0;
        @(negedge clk); #1;
        mem.delete();
        fill_word = 32'd0;
        mem[2 * 32768 + 'h100] = 32'h1234_5678;
        mem[2 * 32768 + 'h101] = 32'h9ABC_DEF0;
        run_cmd("after_rst", 9'd10, 16'h0100, 3'd2, 2'd1, 1'b0, 7'h55, 10'h200, 1'b0, 1'b0, 1'b0);

        // randomised commands, issued back to back
        for (int t = 0; t < 12; t++) begin
            mem.delete();
            fill_word = rand_word(1'b0);
            case ($urandom_range(3, 0))
                0: off = 16'h7FFF;
                1: off = 16'h0000;
                default: off = 16'($urandom);
            endcase
            bank = 3'($urandom_range(7, 0));
            for (int k = -140; k <= 140; k++)
                mem[int'(bank) * 32768 + ((int'(off[14:0]) + k + 32768) % 32768)] = rand_word(1'b1);
            case ($urandom_range(4, 0))
                0: hz = 10'h200;
                1: hz = 10'h100;
                2: hz = 10'($urandom_range(1023, 1));
                3: hz = 10'h3FF;
                default: hz = 10'($urandom_range(10'h300, 10'h080));
            endcase
            lat_max  = $urandom_range(4, 0);
            spurious = 1'($urandom_range(1, 0));
            run_cmd($sformatf("rand%0d", t), 9'($urandom), off, bank, 2'($urandom),
                    1'($urandom), 7'($urandom), hz, 1'($urandom), 1'($urandom), 1'b0);
        end

        check("no_write_with_rom_cs", overlap, 0);
        check("rom_cs_held_until_ok", cs_drop, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
